// File: rtl/adder_sequencer.sv
// Three-state command sequencer in front of an external 5-bit adder datapath.
// It latches the operands, captures one result per command, and keeps a saturating accumulator.
module adder_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [4:0] req_a,
  input  logic [4:0] req_b,
  output logic [4:0] dp_a,
  output logic [4:0] dp_b,
  input  logic [4:0] dp_sum,
  input  logic [4:0] dp_abs_sum,
  input  logic [4:0] dp_diff,
  input  logic       dp_of_add,
  input  logic       dp_of_sub,
  input  logic       dp_lessthan,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_data,
  output logic       rsp_flag,
  output logic [4:0] acc,
  output logic [7:0] op_count
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAbs = 3'b010;
  localparam logic [2:0] OpLt  = 3'b011;
  localparam logic [2:0] OpAcc = 3'b100;
  localparam logic [2:0] OpClr = 3'b101;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e     state_q;
  logic [2:0] op_q;
  logic [4:0] res_data;
  logic       res_flag;
  logic [4:0] acc_d;

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);

  // Result selection from the datapath for the latched op.
  always_comb begin
    res_data = 5'd0;
    res_flag = 1'b0;
    acc_d    = acc;
    case (op_q)
      OpAdd: begin
        res_data = dp_sum;
        res_flag = dp_of_add;
      end
      OpSub: begin
        res_data = dp_diff;
        res_flag = dp_of_sub;
      end
      OpAbs: begin
        res_data = dp_abs_sum;
        res_flag = dp_of_add;
      end
      OpLt: begin
        res_data = {4'b0000, dp_lessthan};
      end
      OpAcc: begin
        res_flag = dp_of_add;
        // Overflow saturates toward the sign of the accumulator operand.
        if (dp_of_add) begin
          res_data = dp_a[4] ? 5'b10000 : 5'b01111;
        end else begin
          res_data = dp_sum;
        end
        acc_d = res_data;
      end
      OpClr: begin
        acc_d = 5'd0;
      end
      default: begin
        res_flag = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      dp_a     <= 5'd0;
      dp_b     <= 5'd0;
      rsp_data <= 5'd0;
      rsp_flag <= 1'b0;
      acc      <= 5'd0;
      op_count <= 8'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q <= req_op;
            if (req_op == OpAcc) begin
              dp_a <= acc;
              dp_b <= req_a;
            end else begin
              dp_a <= req_a;
              dp_b <= req_b;
            end
            state_q <= StExec;
          end
        end
        StExec: begin
          rsp_data <= res_data;
          rsp_flag <= res_flag;
          acc      <= acc_d;
          state_q  <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            op_count <= op_count + 8'd1;
            state_q  <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sequencer.sv
// Scoreboard bench for adder_sequencer with a behavioural model of the external adder datapath.
module tb_adder_sequencer;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [4:0] req_a;
  logic [4:0] req_b;
  logic [4:0] dp_a;
  logic [4:0] dp_b;
  logic [4:0] dp_sum;
  logic [4:0] dp_abs_sum;
  logic [4:0] dp_diff;
  logic       dp_of_add;
  logic       dp_of_sub;
  logic       dp_lessthan;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_data;
  logic       rsp_flag;
  logic [4:0] acc;
  logic [7:0] op_count;

  typedef struct packed {
    logic [4:0] data;
    logic       flag;
    logic [4:0] acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt_model = 0;

  adder_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_sum     (dp_sum),
    .dp_abs_sum (dp_abs_sum),
    .dp_diff    (dp_diff),
    .dp_of_add  (dp_of_add),
    .dp_of_sub  (dp_of_sub),
    .dp_lessthan(dp_lessthan),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_flag   (rsp_flag),
    .acc        (acc),
    .op_count   (op_count)
  );

  // External combinational datapath.
  assign dp_sum      = dp_a + dp_b;
  assign dp_diff     = dp_a - dp_b;
  assign dp_abs_sum  = dp_sum[4] ? (5'd0 - dp_sum) : dp_sum;
  assign dp_of_add   = (dp_a[4] == dp_b[4]) && (dp_sum[4] != dp_a[4]);
  assign dp_of_sub   = (dp_a[4] != dp_b[4]) && (dp_diff[4] != dp_a[4]);
  assign dp_lessthan = ($signed(dp_a) < $signed(dp_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor: compare each handshaken response against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      cnt_model = 0;
    end else if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_data", int'(rsp_data), int'(mon_e.data));
        check("rsp_flag", int'(rsp_flag), int'(mon_e.flag));
        check("acc", int'(acc), int'(mon_e.acc));
        check("op_count", int'(op_count), cnt_model);
        cnt_model = (cnt_model + 1) % 256;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] ed, input logic ef, input logic [4:0] ea);
    exp_t e;
    int   w;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) check("accept_timeout", 0, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    e.data = ed;
    e.flag = ef;
    e.acc  = ea;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("exec_no_valid", int'(rsp_valid), 0);
    @(posedge clk);
    #1;
    check("latency2", int'(rsp_valid), 1);
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!req_ready) check("return_timeout", 0, 1);
  endtask

  initial begin
    exp_t e;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 5'd0;
    req_b     = 5'd0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_data", int'(rsp_data), 0);
    check("rst_rsp_flag", int'(rsp_flag), 0);
    check("rst_dp_a", int'(dp_a), 0);
    check("rst_dp_b", int'(dp_b), 0);
    check("rst_acc", int'(acc), 0);
    check("rst_op_count", int'(op_count), 0);

    //   op    a      b      data   flag  acc
    send(3'd0, 5'd4,  5'd8,  5'd12, 1'b0, 5'd0);   // ADD 4+8
    send(3'd0, 5'd8,  5'd12, 5'd20, 1'b1, 5'd0);   // ADD 8+12 -> -12, overflow
    send(3'd1, 5'd5,  5'd17, 5'd20, 1'b1, 5'd0);   // SUB 5-(-15) -> -12, overflow
    send(3'd3, 5'd20, 5'd8,  5'd1,  1'b0, 5'd0);   // LT -12<8
    send(3'd3, 5'd20, 5'd16, 5'd0,  1'b0, 5'd0);   // LT -12<-16
    send(3'd7, 5'd3,  5'd4,  5'd0,  1'b1, 5'd0);   // illegal
    send(3'd2, 5'd3,  5'd23, 5'd6,  1'b0, 5'd0);   // ABS 3+(-9)
    send(3'd2, 5'd10, 5'd10, 5'd12, 1'b1, 5'd0);   // ABS of wrapped 20
    send(3'd5, 5'd9,  5'd9,  5'd0,  1'b0, 5'd0);   // CLR
    send(3'd4, 5'd13, 5'd0,  5'd13, 1'b0, 5'd13);  // ACC 13
    send(3'd4, 5'd7,  5'd0,  5'd15, 1'b1, 5'd15);  // ACC 7 saturates +15
    send(3'd4, 5'd16, 5'd0,  5'd31, 1'b0, 5'd31);  // ACC -16 -> -1

    // Stall in RESP with a competing request held high.
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd1;
    req_a     = 5'd3;
    req_b     = 5'd5;
    e.data = 5'd30;
    e.flag = 1'b0;
    e.acc  = 5'd31;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_op = 3'd0;
    req_a  = 5'd1;
    req_b  = 5'd1;
    @(posedge clk);
    #1;
    repeat (5) begin
      @(negedge clk);
      check("stall_rsp_valid", int'(rsp_valid), 1);
      check("stall_rsp_data", int'(rsp_data), 30);
      check("stall_rsp_flag", int'(rsp_flag), 0);
      check("stall_req_ready", int'(req_ready), 0);
      check("stall_op_count", int'(op_count), 12);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("stall_done_idle", int'(req_ready), 1);
    check("stall_done_count", int'(op_count), 13);
    @(posedge clk);
    #1;
    check("no_buffered_req", int'(rsp_valid), 0);

    // Abort an ACC with reset while in EXEC.
    send(3'd5, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);      // CLR
    send(3'd4, 5'd3, 5'd0, 5'd3, 1'b0, 5'd3);      // ACC 3
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_a     = 5'd5;
    req_b     = 5'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_req_ready", int'(req_ready), 1);
    check("abort_acc", int'(acc), 0);
    check("abort_rsp_valid", int'(rsp_valid), 0);
    check("abort_op_count", int'(op_count), 0);
    @(posedge clk);
    #1;
    check("abort_no_rsp", int'(rsp_valid), 0);
    send(3'd0, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0);      // ADD after reset

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    check("final_op_count", int'(op_count), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
